// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the clock-rate monitor scan scheduler.
package clk_mon_pkg;

  localparam int RATE_W_DEF = 24;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    START,
    WAIT,
    STORE,
    NEXT
  } sched_state_t;

  typedef struct packed {
    logic [RATE_W_DEF-1:0] rate;
    logic                  valid;
    logic                  tmo;
    logic                  alarm;
  } chan_result_t;

endpackage

// File: rtl/clk_mon_limit_chk.sv
// Per-channel range check and alarm flop.
// CLK_MON_SCHED_STICKY_EN: alarm latches until alarm_clr (a coincident set wins);
// otherwise alarm follows the latest stored measurement and clr is ignored.
module clk_mon_limit_chk #(
  parameter int RATE_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              store,
  input  logic [RATE_W-1:0] value,
  input  logic              tmo,
  input  logic [RATE_W-1:0] thr_lo,
  input  logic [RATE_W-1:0] thr_hi,
  input  logic              clr,
  output logic              alarm,
  output logic              rise
);

  logic bad;

  // A timeout is always an alarm; lo > hi makes every value out of range.
  assign bad  = tmo || (value < thr_lo) || (value > thr_hi);
  assign rise = store && bad && !alarm;

`ifdef CLK_MON_SCHED_STICKY_EN
  // Sticky alarm: set by a bad store, cleared only by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
    end else if (store && bad) begin
      alarm <= 1'b1;
    end else if (clr) begin
      alarm <= 1'b0;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;

  // Alarm mirrors the result of the most recent store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
    end else if (store) begin
      alarm <= bad;
    end
  end
`endif

endmodule

// File: rtl/clk_mon_scan_sched.sv
// Round-robin scheduler sharing one clock-rate measurement engine across NCLK clocks.
// Optional build macro: CLK_MON_SCHED_STICKY_EN (sticky alarms, see clk_mon_limit_chk).
//
//  state  | meaning
//  IDLE   | waiting for scan_en and a non-empty channel mask
//  SELECT | drive eng_sel with the chosen channel, load settle timer
//  SETTLE | let the external clock mux settle
//  START  | eng_start high for this one cycle, load timeout timer
//  WAIT   | wait for eng_done or timeout terminal count
//  STORE  | write rate/valid/timeout, update alarm
//  NEXT   | advance to next enabled channel, count wrapped passes
module clk_mon_scan_sched
  import clk_mon_pkg::*;
#(
  parameter  int NCLK        = 4,
  parameter  int RATE_W      = RATE_W_DEF,
  parameter  int SETTLE_CYC  = 16,
  parameter  int TIMEOUT_CYC = 2**20,
  localparam int SEL_W       = (NCLK > 1) ? $clog2(NCLK) : 1
) (
  input  logic                     clk_ref,
  input  logic                     aresetn,
  input  logic                     scan_en,
  input  logic [NCLK-1:0]          chan_mask,
  input  logic [NCLK*RATE_W-1:0]   thr_lo,
  input  logic [NCLK*RATE_W-1:0]   thr_hi,
  input  logic [NCLK-1:0]          alarm_clr,
  output logic [SEL_W-1:0]         eng_sel,
  output logic                     eng_start,
  input  logic                     eng_done,
  input  logic [RATE_W-1:0]        eng_value,
  output logic [NCLK*RATE_W-1:0]   rate_out,
  output logic [NCLK-1:0]          rate_valid,
  output logic [NCLK-1:0]          timeout,
  output logic [NCLK-1:0]          alarm,
  output logic [31:0]              scan_count,
  output logic                     irq
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  sched_state_t      state;
  logic [SEL_W-1:0]  ch;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  ch_inc;
  logic [SEL_W-1:0]  nxt_ch;
  logic [SET_W-1:0]  settle_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [RATE_W-1:0] val_q;
  logic              tmo_q;
  logic [NCLK-1:0]   store_vec;
  logic [NCLK-1:0]   rise;

  // Lowest set mask bit at or after 'from', wrapping; returns 'from' when the mask is empty.
  function automatic logic [SEL_W-1:0] pick(input logic [NCLK-1:0] m, input logic [SEL_W-1:0] from);
    logic [2*NCLK-1:0] dbl;
    int off;
    int idx;
    dbl = {m, m} >> from;
    off = 0;
    for (int k = NCLK - 1; k >= 0; k--) begin
      if (dbl[k]) off = k;
    end
    idx = int'(from) + off;
    if (idx >= NCLK) idx = idx - NCLK;
    return SEL_W'(idx);
  endfunction

  assign ch_inc = (ch == SEL_W'(NCLK - 1)) ? '0 : ch + 1'b1;
  assign nxt_ch = pick(chan_mask, ch_inc);

  // One-hot write strobe for the channel being stored.
  always_comb begin
    store_vec = '0;
    for (int i = 0; i < NCLK; i++) begin
      store_vec[i] = (state == STORE) && (ch == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < NCLK; g++) begin : g_chk
    clk_mon_limit_chk #(.RATE_W(RATE_W)) u_chk (
      .clk    (clk_ref),
      .rst_n  (aresetn),
      .store  (store_vec[g]),
      .value  (val_q),
      .tmo    (tmo_q),
      .thr_lo (thr_lo[g*RATE_W +: RATE_W]),
      .thr_hi (thr_hi[g*RATE_W +: RATE_W]),
      .clr    (alarm_clr[g]),
      .alarm  (alarm[g]),
      .rise   (rise[g])
    );
  end

  // Scan FSM with its timers, pointer, result registers and registered outputs.
  always_ff @(posedge clk_ref or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      ch         <= '0;
      ptr        <= '0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      val_q      <= '0;
      tmo_q      <= 1'b0;
      eng_sel    <= '0;
      eng_start  <= 1'b0;
      rate_out   <= '0;
      rate_valid <= '0;
      timeout    <= '0;
      scan_count <= '0;
      irq        <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      irq       <= |rise;
      case (state)
        IDLE: begin
          if (scan_en && |chan_mask) begin
            ch    <= pick(chan_mask, ptr);
            state <= SELECT;
          end
        end
        SELECT: begin
          eng_sel    <= ch;
          settle_cnt <= SET_W'(SETTLE_CYC - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            eng_start <= 1'b1;
            state     <= START;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        START: begin
          tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
          state   <= WAIT;
        end
        WAIT: begin
          // done is tested first so a done on the terminal cycle is a real result
          if (eng_done) begin
            val_q <= eng_value;
            tmo_q <= 1'b0;
            state <= STORE;
          end else if (tmo_cnt == '0) begin
            val_q <= '0;
            tmo_q <= 1'b1;
            state <= STORE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        STORE: begin
          for (int i = 0; i < NCLK; i++) begin
            if (store_vec[i]) begin
              rate_out[i*RATE_W +: RATE_W] <= val_q;
              rate_valid[i]                <= 1'b1;
              timeout[i]                   <= tmo_q;
            end
          end
          state <= NEXT;
        end
        NEXT: begin
          if (|chan_mask) begin
            ptr <= nxt_ch;
            ch  <= nxt_ch;
            if (nxt_ch <= ch) scan_count <= scan_count + 32'd1;
          end else begin
            ptr <= ch_inc;
          end
          state <= (scan_en && |chan_mask) ? SELECT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_mon_scan_sched.sv
// Self-checking bench for clk_mon_scan_sched with a rule-level reference model.
module tb_clk_mon_scan_sched;

  localparam int N   = 4;
  localparam int RW  = 24;
  localparam int SC  = 4;
  localparam int TMO = 64;

  logic            clk;
  logic            aresetn;
  logic            scan_en;
  logic [N-1:0]    chan_mask;
  logic [N*RW-1:0] thr_lo;
  logic [N*RW-1:0] thr_hi;
  logic [N-1:0]    alarm_clr;
  logic [1:0]      eng_sel;
  logic            eng_start;
  logic            eng_done;
  logic [RW-1:0]   eng_value;
  logic [N*RW-1:0] rate_out;
  logic [N-1:0]    rate_valid;
  logic [N-1:0]    timeout;
  logic [N-1:0]    alarm;
  logic [31:0]     scan_count;
  logic            irq;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] m_rate [N];
  logic [N-1:0]  m_valid, m_tmo, m_alarm;
  int            m_ptr, m_cur;
  logic [31:0]   m_count;

  clk_mon_scan_sched #(
    .NCLK(N), .RATE_W(RW), .SETTLE_CYC(SC), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_ref(clk), .aresetn(aresetn), .scan_en(scan_en), .chan_mask(chan_mask),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .alarm_clr(alarm_clr),
    .eng_sel(eng_sel), .eng_start(eng_start), .eng_done(eng_done), .eng_value(eng_value),
    .rate_out(rate_out), .rate_valid(rate_valid), .timeout(timeout), .alarm(alarm),
    .scan_count(scan_count), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find_from(input logic [N-1:0] m, input int from);
    for (int k = 0; k < N; k++) begin
      if (m[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*RW-1:0] packed_rates();
    logic [N*RW-1:0] p;
    for (int i = 0; i < N; i++) p[i*RW +: RW] = m_rate[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_rate[i] = '0;
    m_valid = '0; m_tmo = '0; m_alarm = '0;
    m_ptr = 0; m_count = '0; m_cur = -1;
  endtask

  task automatic set_thr(input int i, input int lo, input int hi);
    thr_lo[i*RW +: RW] = RW'(lo);
    thr_hi[i*RW +: RW] = RW'(hi);
  endtask

  task automatic resume(input logic [N-1:0] m, input bit en);
    chan_mask = m;
    scan_en   = en;
    if (en && (m != '0)) m_cur = find_from(m, m_ptr);
  endtask

  task automatic expect_idle(input int cyc);
    bit seen = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (eng_start) seen = 1;
    end
    chk("idle_no_start", seen, 0);
  endtask

  // One full channel measurement; mask/scan_en are changed while the engine is busy.
  task automatic step(input bit respond, input logic [RW-1:0] v, input int dly,
                      input logic [N-1:0] clr, input logic [N-1:0] nmask, input bit nen);
    bit got = 0;
    int ch, lo, hi;
    logic [RW-1:0] veff;
    bit bad, old, exp_irq;
    ch = m_cur;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (eng_start) begin got = 1; break; end
    end
    chk("start_seen", got, 1);
    chk("eng_sel", eng_sel, ch);
    chk("scan_count", scan_count, m_count);
    chk("irq_quiet", irq, 0);
    chan_mask = nmask;
    scan_en   = nen;
    @(negedge clk);
    chk("start_pulse_width", eng_start, 0);
    alarm_clr = clr;
`ifdef CLK_MON_SCHED_STICKY_EN
    m_alarm = m_alarm & ~clr;
`endif
    @(negedge clk);
    alarm_clr = '0;
    if (respond) begin
      repeat (dly - 2) @(negedge clk);
      eng_done = 1'b1; eng_value = v;
      @(negedge clk);
      eng_done = 1'b0;
      @(negedge clk);
    end else begin
      repeat (TMO) @(negedge clk);
    end
    veff = respond ? v : '0;
    lo   = int'(thr_lo[ch*RW +: RW]);
    hi   = int'(thr_hi[ch*RW +: RW]);
    bad  = !respond || (int'(veff) < lo) || (int'(veff) > hi);
    old  = m_alarm[ch];
    exp_irq = bad && !old;
`ifdef CLK_MON_SCHED_STICKY_EN
    m_alarm[ch] = old | bad;
`else
    m_alarm[ch] = bad;
`endif
    m_rate[ch] = veff; m_valid[ch] = 1'b1; m_tmo[ch] = !respond;
    chk("rate_out", rate_out, packed_rates());
    chk("rate_valid", rate_valid, m_valid);
    chk("timeout", timeout, m_tmo);
    chk("alarm", alarm, m_alarm);
    chk("irq", irq, exp_irq);
    if (nmask != '0) begin
      int nx = find_from(nmask, (ch + 1) % N);
      if (nx <= ch) m_count++;
      m_ptr = nx;
      m_cur = nen ? nx : -1;
    end else begin
      m_ptr = (ch + 1) % N;
      m_cur = -1;
    end
  endtask

  function automatic logic [RW-1:0] rand_val();
    case ($urandom_range(0, 5))
      0: return RW'(99);
      1: return RW'(100);
      2: return RW'(500);
      3: return RW'(501);
      default: return RW'($urandom_range(0, 700));
    endcase
  endfunction

  initial begin
    aresetn = 1'b0; scan_en = 1'b0; chan_mask = '0; alarm_clr = '0;
    eng_done = 1'b0; eng_value = '0; thr_lo = '0; thr_hi = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_eng_sel", eng_sel, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_rate_out", rate_out, 0);
    chk("rst_rate_valid", rate_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_scan_count", scan_count, 0);
    chk("rst_irq", irq, 0);
    aresetn = 1'b1;
    chan_mask = 4'b1111;
    expect_idle(10);

    // Basic pass with all channels in range.
    for (int i = 0; i < N; i++) set_thr(i, 50, 500);
    resume(4'b1111, 1'b1);
    step(1, 24'd100, 2, 4'b0000, 4'b1111, 1);
    step(1, 24'd200, 3, 4'b0000, 4'b1111, 1);
    step(1, 24'd300, 4, 4'b0000, 4'b1111, 1);
    step(1, 24'd400, 5, 4'b0000, 4'b1111, 1);
    step(1, 24'd250, 2, 4'b0000, 4'b1111, 1);

    // Inclusive boundaries, then timeout on channel 1, then recovery.
    for (int i = 0; i < N; i++) set_thr(i, 100, 500);
    step(1, 24'd100, 2, 4'b0000, 4'b1111, 1);
    step(1, 24'd500, 3, 4'b0000, 4'b1111, 1);
    step(1, 24'd99,  2, 4'b0000, 4'b1111, 1);
    step(1, 24'd501, 4, 4'b0000, 4'b1111, 1);
    step(0, 24'd0,   2, 4'b0000, 4'b1111, 1);
    step(1, 24'd300, 2, 4'b0000, 4'b1111, 1);
    step(1, 24'd250, 3, 4'b0000, 4'b1111, 1);
    step(1, 24'd300, 2, 4'b0001, 4'b1111, 1);

    // Random values with an inverted window on channel 3 and random clears.
    set_thr(3, 600, 50);
    for (int s = 0; s < 16; s++) begin
      step(1, rand_val(), $urandom_range(2, 6), N'($urandom_range(0, 15)), 4'b1111, 1);
    end
    set_thr(3, 100, 500);

    // Sparse mask, then clear the mask while channel 2 is measuring.
    step(1, rand_val(), 2, 4'b0000, 4'b0101, 1);
    for (int s = 0; s < 4 && m_cur != 2; s++) step(1, rand_val(), 3, 4'b0000, 4'b0101, 1);
    chk("reach_ch2", m_cur, 2);
    step(1, 24'd321, 2, 4'b0000, 4'b0000, 1);
    expect_idle(30);
    resume(4'b0101, 1'b1);
    step(1, rand_val(), 2, 4'b0000, 4'b0101, 1);
    step(1, rand_val(), 4, 4'b0000, 4'b0101, 1);
    step(1, rand_val(), 2, 4'b0000, 4'b0101, 0);
    expect_idle(30);
    resume(4'b1111, 1'b1);
    step(1, rand_val(), 3, 4'b0000, 4'b1111, 1);

    // Reset in the middle of a measurement; a late done must be ignored.
    begin
      bit got = 0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (eng_start) begin got = 1; break; end
      end
      chk("pre_reset_start", got, 1);
      repeat (2) @(negedge clk);
      aresetn = 1'b0;
      @(negedge clk);
      chk("wrst_rate_out", rate_out, 0);
      chk("wrst_rate_valid", rate_valid, 0);
      chk("wrst_alarm", alarm, 0);
      chk("wrst_timeout", timeout, 0);
      chk("wrst_scan_count", scan_count, 0);
      chk("wrst_eng_sel", eng_sel, 0);
      @(negedge clk);
      aresetn = 1'b1;
      eng_done = 1'b1; eng_value = 24'd777;
      @(negedge clk);
      eng_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("late_done_valid", rate_valid, 0);
      chk("late_done_rate", rate_out, 0);
      model_reset();
      m_cur = find_from(chan_mask, 0);
    end
    step(1, 24'd150, 2, 4'b0000, 4'b1111, 1);
    step(1, 24'd600, 3, 4'b0000, 4'b1111, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
